// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   INST_W / OPCODE_W : instruction word and opcode field widths
//   PC_STEP           : byte distance between consecutive instruction words
//   OP_*              : primary opcode values seen by the control unit
//   fetch_entry_t     : one fetched word together with the PC it came from
//   pc_next()         : sequential successor of a word-aligned PC (wraps at 2^32)
package mips_pkg;

  localparam int          INST_W   = 32;
  localparam int          OPCODE_W = 6;
  localparam logic [31:0] PC_STEP  = 32'd4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LH    = 6'h21;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_LHU   = 6'h25;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_entry at the tail
//   push_entry  : entry to write
//   pop         : retire the head entry
//   flush       : drop all entries (wins over push/pop)
//   count       : number of valid entries (0..DEPTH)
//   head        : head entry, registered storage read (meaningful when count != 0)
// There is no overflow or underflow protection: the owner only pushes when a
// slot was reserved for the word and only pops a valid head.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads to
// instruction memory and buffers returned words with their PCs for decode.
//   clk, reset       : clock, synchronous active-high reset
//   imem_req_*       : read request channel (valid/ready, addr = pc_q)
//   imem_resp_*      : read response, in order, never stalled
//   redirect_valid/pc: taken branch/jump, flushes buffer and in-flight reads
//   inst_*           : buffer head toward decode (valid/ready), inst_opcode = inst_data[31:26]
//
// Handshakes: a transfer happens in a cycle where valid and ready are both 1.
// valid never depends on ready; ready may depend on anything.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [31:0]         imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_W-1:0]   imem_resp_data,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_W-1:0]   inst_data,
  output logic [31:0]         inst_pc,
  output logic [OPCODE_W-1:0] inst_opcode
);

  localparam int           CW  = $clog2(DEPTH + 1);
  localparam logic [CW:0]  CAP = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   rpc_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;

  logic          credit_ok;
  logic          req_fire;
  logic          resp_take;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_target;
  logic          unused_pc_bits;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits  = ^redirect_pc[1:0];

  // Every in-flight read owns a buffer slot, so a response can always be stored.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, count}) < CAP;
  assign imem_req_valid = !reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with no read in flight is a protocol error and is ignored.
  assign resp_take  = imem_resp_valid && (outstanding != '0);
  assign push       = resp_take && (drop_cnt == '0) && !redirect_valid;
  assign push_entry = '{pc: rpc_q, inst: imem_resp_data};

  assign inst_valid  = !reset && !redirect_valid && (count != '0);
  assign pop         = inst_valid && inst_ready;
  assign inst_data   = head.inst;
  assign inst_pc     = head.pc;
  assign inst_opcode = head.inst[31:26];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      rpc_q       <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
      if (redirect_valid) begin
        pc_q     <= redirect_target;
        rpc_q    <= redirect_target;
        // Everything still in flight after this cycle is stale; a response
        // arriving right now is discarded by the flush itself.
        drop_cnt <= outstanding - CW'(resp_take);
      end else begin
        if (req_fire) pc_q <= pc_next(pc_q);
        if (resp_take) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
          else                rpc_q    <= pc_next(rpc_q);
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head)
  );

  resp_needs_credit: assert property (@(posedge clk) disable iff (reset)
    !(imem_resp_valid && (outstanding == '0)));

endmodule
